// File: rtl/audio_pkg.sv
// Shared audio definitions: sample word format, frame geometry and the
// request handshake state encoding used by the codec sample feeder.
package audio_pkg;

    localparam int SAMPLE_BITS = 16;
    localparam int FRAME_BITS  = 32;

    typedef logic signed [SAMPLE_BITS-1:0] sample_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } req_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO. dout presents the head entry combinationally whenever
// the FIFO is non-empty. A pop on an empty FIFO and a push on a full FIFO
// are ignored, so a simultaneous push and pop on an empty FIFO only pushes.
module sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CW'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage write; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/codec_sample_feeder.sv
// Pulls mono samples from the chord player through a request/strobe
// handshake, buffers them, and plays each one into both slots of a
// left-justified 2x16-bit serial codec frame.
module codec_sample_feeder
    import audio_pkg::*;
#(
    parameter int BCLK_HALF   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int REQ_TIMEOUT = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          generate_next_sample,
    input  logic                          new_sample_ready,
    input  logic signed [SAMPLE_BITS-1:0] sample_in,
    output logic                          bclk,
    output logic                          lrclk,
    output logic                          sdata,
    output logic                          underrun,
    output logic                          req_timeout
);

    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int WW    = $clog2(REQ_TIMEOUT) + 1;
    localparam int CNT_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BIT_W = $clog2(FRAME_BITS);

    req_state_t       r_state;
    req_state_t       w_state_nxt;
    logic             w_issue;
    logic             w_push;
    logic             w_timeout;
    logic             r_gen;
    logic             r_timeout;
    logic [WW-1:0]    r_wait;

    logic [CW-1:0]    w_count;
    logic             w_empty;
    logic             w_full;
    sample_t          w_dout;
    sample_t          w_word;

    logic [CNT_W-1:0] r_cnt;
    logic             r_bclk;
    logic [BIT_W-1:0] r_bit_idx;
    logic             w_tick;
    logic             w_fall;
    logic             w_frame_start;
    logic             w_pop;
    logic             r_primed;
    logic             r_underrun;
    logic             r_sdata;
    sample_t          r_hold;
    sample_t          r_shift;

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push & ~w_full),
        .pop   (w_pop),
        .din   (sample_in),
        .dout  (w_dout),
        .count (w_count),
        .empty (w_empty),
        .full  (w_full)
    );

    // Request FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request FSM: ask whenever there is room, then wait for the strobe or give up.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_push      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_count < CW'(FIFO_DEPTH)) begin
                    w_state_nxt = ST_WAIT;
                    w_issue     = 1'b1;
                end
            end
            ST_WAIT: begin
                if (new_sample_ready) begin
                    w_state_nxt = ST_IDLE;
                    w_push      = 1'b1;
                end else if (r_wait == WW'(REQ_TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_timeout   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered request and timeout pulses, plus the cycles-in-WAIT counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gen     <= 1'b0;
            r_timeout <= 1'b0;
            r_wait    <= '0;
        end else begin
            r_gen     <= w_issue;
            r_timeout <= w_timeout;
            r_wait    <= (r_state == ST_WAIT) ? r_wait + WW'(1) : '0;
        end
    end

    assign w_tick        = (r_cnt == CNT_W'(BCLK_HALF - 1));
    assign w_fall        = w_tick & r_bclk;
    assign w_frame_start = w_fall & (r_bit_idx == BIT_W'(FRAME_BITS - 1));
    assign w_pop         = w_frame_start & ~w_empty;
    assign w_word        = w_empty ? sample_t'(0) : w_dout;

    // BCLK divider and bit position within the frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bclk    <= 1'b0;
            r_bit_idx <= BIT_W'(FRAME_BITS - 1);
        end else begin
            if (w_tick) begin
                r_cnt  <= '0;
                r_bclk <= ~r_bclk;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_fall) begin
                r_bit_idx <= r_bit_idx + BIT_W'(1);
            end
        end
    end

    // Underrun reporting stays quiet until the first sample has actually played.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_primed   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_frame_start & w_empty & r_primed;
            if (w_pop) begin
                r_primed <= 1'b1;
            end
        end
    end

    // Hold register and shifter: load at frame start, reload for the right slot.
    always_ff @(posedge clk) begin
        if (w_fall) begin
            if (w_frame_start) begin
                r_hold  <= w_word;
                r_shift <= {w_word[SAMPLE_BITS-2:0], 1'b0};
            end else if (r_bit_idx == BIT_W'(SAMPLE_BITS - 1)) begin
                r_shift <= {r_hold[SAMPLE_BITS-2:0], 1'b0};
            end else begin
                r_shift <= {r_shift[SAMPLE_BITS-2:0], 1'b0};
            end
        end
    end

    // Serial data output, updated only on BCLK falling edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sdata <= 1'b0;
        end else if (w_fall) begin
            if (w_frame_start) begin
                r_sdata <= w_word[SAMPLE_BITS-1];
            end else if (r_bit_idx == BIT_W'(SAMPLE_BITS - 1)) begin
                r_sdata <= r_hold[SAMPLE_BITS-1];
            end else begin
                r_sdata <= r_shift[SAMPLE_BITS-1];
            end
        end
    end

    assign generate_next_sample = r_gen;
    assign req_timeout          = r_timeout;
    assign underrun             = r_underrun;
    assign bclk                 = r_bclk;
    assign lrclk                = r_bit_idx[BIT_W-1];
    assign sdata                = r_sdata;

endmodule

// File: doc/codec_sample_feeder.md
# codec_sample_feeder

Consumer end of the chord player's sample handshake: it issues `generate_next_sample` requests, captures each `sample_in` word on `new_sample_ready`, and buffers the words in a small FIFO. It serializes one mono sample per frame onto a left-justified, two-slot, 16-bit serial codec link, sending the same sample in both the left and right slots. It sits between `chord_player` and the board audio codec pins.

## Interface
- `BCLK_HALF`, default 4: clk cycles per BCLK half-period. Sample rate is clk/(64·BCLK_HALF).
- `FIFO_DEPTH`, default 4: sample FIFO entries; a power of two, at least 2.
- `REQ_TIMEOUT`, default 64: clk cycles to wait for `new_sample_ready` before abandoning a request.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `generate_next_sample`  out  1  one-cycle request pulse to the chord player
- `new_sample_ready`  in  1  one-cycle strobe; `sample_in` is valid in the same cycle
- `sample_in`  in  16  signed sample from the chord player
- `bclk`  out  1  codec bit clock
- `lrclk`  out  1  0 = left slot, 1 = right slot
- `sdata`  out  1  serial data, MSB first; changes on the BCLK falling edge
- `underrun`  out  1  one-cycle pulse: a frame started with the FIFO empty
- `req_timeout`  out  1  one-cycle pulse: a request was abandoned

## Operation
- **Request FSM, states IDLE and WAIT.**
  - IDLE → WAIT when `fifo_count < FIFO_DEPTH`; `generate_next_sample` is high for exactly the one cycle after that transition is taken (registered output).
  - WAIT → IDLE on `new_sample_ready`; `sample_in` is pushed into the FIFO.
  - WAIT → IDLE when the wait counter reaches `REQ_TIMEOUT`; `req_timeout` pulses and nothing is pushed.
  - At most one request is outstanding, so a push can never overflow the FIFO.
- `new_sample_ready` received in IDLE is ignored: no push, no state change.
- **Serializer.**
  - Divider `cnt` counts 0..BCLK_HALF-1. At wrap, `bclk` toggles.
  - On each falling toggle (1→0), `bit_idx` advances mod 32. `lrclk = bit_idx[4]`. `sdata` takes the next shift-register bit.
  - When `bit_idx` wraps 31→0 (frame start), the FIFO head is popped into a 16-bit hold register, and `sdata` takes its bit 15 on that same edge.
  - Slot bits 0–15 and 16–31 both replay the hold register, MSB first.
- **Underrun.**
  - If the FIFO is empty at frame start, the hold register is loaded with 0 for the whole frame.
  - `underrun` pulses only if the `primed` flag is set. `primed` is set by the first successful pop after reset.
- **Push and pop in the same cycle.**
  - Both occur; the count is unchanged.
  - If the count is 0, the pop sees empty: the frame underruns and the pushed word stays in the FIFO.
- **Arithmetic.** Samples pass through bit-exact, with no scaling or resampling. The counters are unsigned and wrap.

## Timing
- **Reset values:** `generate_next_sample`=0, `bclk`=0, `lrclk`=1 (`bit_idx`=31), `sdata`=0, `underrun`=0, `req_timeout`=0. FIFO empty, FSM IDLE, `primed`=0, `cnt`=0.
- **First request:** `generate_next_sample` is high in the 2nd cycle after `reset` deasserts.
- **First falling BCLK edge:** `bclk` falls at the 2·BCLK_HALF-th clk edge after reset deasserts, with `bit_idx`=0, `lrclk`=0 and the first pop.
- **Push latency:** the sample is pushed on the edge where `new_sample_ready` is high. The next request can go out 2 cycles later.
- **Reset mid-operation:** everything returns to its reset value on the next edge. Outstanding requests and buffered samples are discarded, and `primed` clears.

## Structure
- Shared `audio_pkg`:
  - `SAMPLE_BITS` = 16
  - `FRAME_BITS` = 32
  - the request FSM state enum
  - the `sample_t` signed typedef
- Sub-module `sample_fifo`: a synchronous FIFO parameterized by depth and width. It exposes `push`, `pop`, `din`, `dout`, `count`, `empty`, `full`, and its `dout` is valid combinationally while it is non-empty.
- Top level holds the request FSM, timeout counter, BCLK divider, bit counter and output shift register.

## Test plan
All scenarios use BCLK_HALF=2, FIFO_DEPTH=4, REQ_TIMEOUT=16. A responder model answers each request after 3 cycles unless stated otherwise.

- **Reset:** hold reset 4 cycles → all outputs at their reset values; first `generate_next_sample` pulse in cycle 2 after release; first falling edge of `bclk` at cycle 4.
- **Fill and serialize:** responder returns 16'h8001 → exactly 4 pushes and then no further requests until a pop. The first frame carries 1000000000000001 in both slots, with `lrclk` 0 for 16 BCLKs and then 1 for 16 BCLKs.
- **Timeout:** responder silent → `req_timeout` pulses 16 cycles after the request, the FSM re-requests 1 cycle later, and the FIFO count is unchanged.
- **Underrun:** first prime the FIFO, then keep the responder silent until it drains → at the next frame start `underrun` pulses once and `sdata` stays 0 for all 32 bits.
- **Unsolicited strobe:** pulse `new_sample_ready` with 16'h1234 while in IDLE → the FIFO count and contents are unchanged.
- **Reset mid-frame:** assert reset at `bit_idx`=10 with 3 samples buffered → the next cycle shows reset values, and after release the first frame underruns silently (`primed`=0, no `underrun` pulse).
